// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetches 32-bit instruction words from an instruction memory. It keeps at most
// one read outstanding and presents each returned word to the control unit.
// Control flow is handled by a three-state machine:
//   FETCH : drive a read request at fetch_pc until the memory accepts it.
//   WAIT  : wait for read data; capture it as the presented instruction.
//   ISSUE : hold the instruction until the decoder takes it (stall=0), then
//           advance fetch_pc sequentially or to a jump target.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   stall                 decoder not ready; presented instruction is held
//   jump_en, jump_address redirect for the instruction being consumed
//   imem_req, imem_addr   read request and word-aligned address
//   imem_ready            memory accepts the request this cycle
//   imem_rvalid,
//   imem_rdata            read response
//   instruction, pc,
//   instr_valid           presented instruction word, its address, live flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } state_e;

  // Forces a byte address down to its word boundary. Masking (rather than
  // slicing) keeps every input bit in use.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  state_e      state_q,       state_d;
  logic [31:0] fetch_pc_q,    fetch_pc_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] pc_q,          pc_d;
  logic        instr_valid_q, instr_valid_d;

  // State register and datapath flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= word_align(RESET_PC);
      instruction_q <= 32'h0000_0000;
      pc_q          <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instruction_d = instruction_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      FETCH: begin
        // Read data arriving here (including in the accepting cycle) is stray.
        if (imem_ready) begin
          state_d = WAIT;
        end else begin
          state_d = FETCH;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          instruction_d = imem_rdata;
          pc_d          = fetch_pc_q;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end

      ISSUE: begin
        if (!stall) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
          if (jump_en) begin
            fetch_pc_d = word_align(jump_address);
          end else begin
            // Wraps naturally from 32'hFFFF_FFFC to 32'h0000_0000.
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else begin
          state_d = ISSUE;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean fetch.
        state_d       = FETCH;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Request decode: only in FETCH and never while reset is applied.
  always_comb begin
    if (rst) begin
      imem_req = 1'b0;
    end else if (state_q == FETCH) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
  end

  assign imem_addr   = word_align(fetch_pc_q);
  assign instruction = instruction_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed self-checking bench for instruction_fetch. Expected (pc, word)
// pairs are queued when the bench returns read data and popped when the DUT
// presents an instruction.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_address = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   issue_cyc = 0;
  int   first_issue = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .jump_en      (jump_en),
    .jump_address (jump_address),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the bench.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h3C3C_3C3C;
      32'h0000_0004: return 32'h7C3C_3C3C;
      32'h0000_0008: return 32'hBC3C_3C3C;
      default:       return addr ^ 32'h5A5A_0F01;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a presented instruction and scores it.
  task automatic wait_issue();
    int   n;
    exp_t e;
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (instr_valid !== 1'b1) begin
      check("issue_timeout", {31'd0, instr_valid}, 32'd1);
    end else if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("issue_pc", pc, e.pc);
      check("issue_word", instruction, e.word);
      issue_cyc = cyc;
    end
  endtask

  // One request at addr: accepted at once, data returned the next cycle.
  task automatic do_fetch(input logic [31:0] addr, input bit stray_same_cycle);
    exp_t e;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    imem_ready = 1'b1;
    if (stray_same_cycle) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    tick();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    check("wait_req", {31'd0, imem_req}, 32'd0);
    check("wait_valid", {31'd0, instr_valid}, 32'd0);
    e.pc   = addr;
    e.word = mem_word(addr);
    sb_q.push_back(e);
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(addr);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
    wait_issue();
  endtask

  // Consume the presented instruction, optionally redirecting.
  task automatic consume(input bit jmp, input logic [31:0] jaddr);
    stall        = 1'b0;
    jump_en      = jmp;
    jump_address = jaddr;
    tick();
    jump_en      = 1'b0;
    check("consumed_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_instr", instruction, 32'h0000_0000);
    rst = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0000_0000);

    // Sequential fetch, three cycles per instruction.
    do_fetch(32'h0000_0000, 1'b1);
    first_issue = issue_cyc;
    consume(1'b0, 32'h0000_0000);
    do_fetch(32'h0000_0004, 1'b0);
    check("throughput", issue_cyc - first_issue, 32'd3);
    consume(1'b0, 32'h0000_0000);

    // Stall hold with an ignored jump.
    do_fetch(32'h0000_0008, 1'b0);
    stall        = 1'b1;
    jump_en      = 1'b1;
    jump_address = 32'h0000_0200;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instruction, 32'hBC3C_3C3C);
      check("stall_pc", pc, 32'h0000_0008);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    jump_en = 1'b0;
    consume(1'b0, 32'h0000_0000);
    check("after_stall_addr", imem_addr, 32'h0000_000C);
    check("after_stall_req", {31'd0, imem_req}, 32'd1);

    // Jump with misaligned target.
    do_fetch(32'h0000_000C, 1'b0);
    consume(1'b1, 32'h0000_0103);
    check("jump_addr", imem_addr, 32'h0000_0100);

    // Backpressure, stray rvalid and an ignored jump while in FETCH.
    jump_en      = 1'b1;
    jump_address = 32'h0000_0400;
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = (i == 2);
      imem_rdata  = 32'hCAFE_F00D;
      tick();
      check("bp_addr", imem_addr, 32'h0000_0100);
      check("bp_req", {31'd0, imem_req}, 32'd1);
      check("bp_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b0;
    jump_en     = 1'b0;
    do_fetch(32'h0000_0100, 1'b0);

    // Wrap past the top of the address space.
    consume(1'b1, 32'hFFFF_FFFF);
    do_fetch(32'hFFFF_FFFC, 1'b0);
    consume(1'b0, 32'h0000_0000);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Present a word, then reset while a request is outstanding.
    do_fetch(32'h0000_0000, 1'b0);
    consume(1'b0, 32'h0000_0000);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    check("mid_wait_req", {31'd0, imem_req}, 32'd0);
    rst         = 1'b1;
    stall       = 1'b1;
    jump_en     = 1'b1;
    jump_address = 32'h0000_0800;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    tick();
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_pc", pc, 32'h0000_0000);
    check("mid_rst_instr", instruction, 32'h0000_0000);
    rst     = 1'b0;
    stall   = 1'b0;
    jump_en = 1'b0;
    #1;
    check("mid_first_req", {31'd0, imem_req}, 32'd1);
    check("mid_first_addr", imem_addr, 32'h0000_0000);
    tick();
    imem_rvalid = 1'b0;
    check("late_rvalid_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rvalid_req", {31'd0, imem_req}, 32'd1);
    check("late_rvalid_addr", imem_addr, 32'h0000_0000);
    do_fetch(32'h0000_0000, 1'b0);
    consume(1'b0, 32'h0000_0000);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (word-aligned).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decoder not ready; holds the presented instruction.
- jump_en  in  1  redirect request from control_unit, tied to the currently presented instruction.
- jump_address  in  32  redirect target; bits [1:0] ignored.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address, word-aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instruction  out  32  instruction word presented to control_unit.
- instr_valid  out  1  instruction holds a live word.
- pc  out  32  address of the presented instruction.

Function
REQ-003 The block SHALL implement a state machine with states FETCH, WAIT and ISSUE, and SHALL have at most one memory request outstanding at any time.
REQ-004 FETCH SHALL behave as follows:
- imem_req=1 and imem_addr=fetch_pc.
- If imem_ready=1 at the edge, go to WAIT; otherwise stay in FETCH with address and request held stable.
REQ-005 WAIT SHALL behave as follows:
- imem_req=0.
- On imem_rvalid=1: instruction<=imem_rdata, pc<=fetch_pc, instr_valid<=1, go to ISSUE.
- Otherwise stay in WAIT with no timeout.
REQ-006 imem_rvalid SHALL be ignored in FETCH and ISSUE, with no state or output change.
REQ-007 In ISSUE with stall=1, the state, instruction, pc and instr_valid SHALL all hold.
REQ-008 In ISSUE with stall=0, the instruction is consumed at the edge:
- instr_valid<=0 and state goes to FETCH.
- fetch_pc<= {jump_address[31:2],2'b00} if jump_en=1, else fetch_pc+4.
REQ-009 jump_en SHALL be honoured only in ISSUE with stall=0 and ignored in all other cycles, including ISSUE with stall=1.
REQ-010 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag raised.
REQ-011 Minimum throughput SHALL be one instruction per 3 cycles (FETCH accepted, rvalid next cycle, ISSUE unstalled); imem_rvalid in the same cycle as acceptance SHALL NOT be sampled.
REQ-012 imem_addr[1:0] SHALL always be 2'b00.
REQ-013 All outputs SHALL be registered, except that imem_req and imem_addr may be decoded from state and fetch_pc.

Reset
REQ-014 While rst=1 at an edge, the block SHALL load: state=FETCH, fetch_pc={RESET_PC[31:2],2'b00}, instruction=0, pc=0, instr_valid=0.
REQ-015 During reset cycles imem_req SHALL be 0; in the first cycle after rst falls, imem_req=1 and imem_addr=RESET_PC.
REQ-016 Reset asserted in WAIT SHALL abandon the outstanding request; a late imem_rvalid arriving in FETCH after reset SHALL be ignored per REQ-006.
REQ-017 Reset SHALL take priority over stall, jump_en and imem_rvalid in the same cycle.

Verification
REQ-018 Sequential fetch:
- Stimulus: RESET_PC=0, memory always ready, rvalid one cycle after acceptance, rdata=32'h3C3C3C3C at 0 and 32'h7C3C3C3C at 4, stall=0.
- Response: instr_valid pulses with pc=0 then pc=4, 3 cycles apart, carrying those words.
REQ-019 Stall hold:
- Stimulus: stall=1 for 5 cycles while ISSUE presents 32'hBC3C3C3C at pc=8.
- Response: instruction, pc and instr_valid stay constant; no imem_req; the next request after stall falls is at addr 12.
REQ-020 Jump:
- Stimulus: jump_en=1, jump_address=32'h0000_0103, stall=0 in ISSUE.
- Response: next imem_addr=32'h0000_0100; the jump is ignored if presented with stall=1.
REQ-021 Memory backpressure and stray data:
- Stimulus: imem_ready=0 for 4 cycles, then imem_rvalid pulsed while in FETCH.
- Response: address held stable throughout; the stray data is not captured and instr_valid stays 0.
REQ-022 Wrap:
- Stimulus: fetch at pc=32'hFFFF_FFFC with stall=0, jump_en=0.
- Response: next imem_addr=32'h0000_0000.
REQ-023 Mid-operation reset:
- Stimulus: rst=1 for 1 cycle while in WAIT, then rvalid arrives.
- Response: outputs per REQ-014, the first request is at RESET_PC, and the rvalid is ignored.
